// File: rtl/axi_llc_burst_write_unit_pkg.sv
// rtl/axi_llc_burst_write_unit_pkg.sv - types, defaults and burst arithmetic for the LLC write unit
package axi_llc_burst_write_unit_pkg;
    localparam int unsigned AddrWidthFull        = 32;
    localparam int unsigned IdWidth              = 4;
    localparam int unsigned DataWidth            = 64;
    localparam int unsigned StrbWidth            = DataWidth / 8;
    localparam int unsigned SetAssociativity     = 4;
    localparam int unsigned ByteOffsetLength     = 3;
    localparam int unsigned BlockOffsetLength    = 3;
    localparam int unsigned IndexLength          = 8;
    localparam int unsigned LineOffset           = ByteOffsetLength + BlockOffsetLength;
    localparam int unsigned WChanBufferDepth     = 4;
    localparam int unsigned DefaultDescFifoDepth = 2;
    localparam int unsigned DefaultBFifoDepth    = 2;

    typedef logic [AddrWidthFull-1:0] addr_t;
    typedef logic [1:0]               resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_t;
    typedef enum logic [1:0] {EvictUnit, RefilUnit, WChanUnit, RChanUnit} cache_unit_e;

    typedef struct packed {
        logic [IdWidth-1:0]          a_x_id;
        addr_t                       a_x_addr;
        logic [7:0]                  a_x_len;
        logic [2:0]                  a_x_size;
        burst_t                      a_x_burst;
        resp_t                       x_resp;
        logic                        x_last;
        logic [SetAssociativity-1:0] way_ind;
    } desc_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        resp_t              resp;
    } b_chan_t;

    typedef struct packed {
        logic [IndexLength-1:0]      index;
        logic [SetAssociativity-1:0] way_ind;
    } lock_t;

    typedef struct packed {
        cache_unit_e                  cache_unit;
        logic                         we;
        logic [SetAssociativity-1:0]  way_ind;
        addr_t                        addr;
        logic [IndexLength-1:0]       line_addr;
        logic [BlockOffsetLength-1:0] blk_offset;
        logic [DataWidth-1:0]         data;
        logic [StrbWidth-1:0]         strb;
    } way_inp_t;

    // Numeric AXI encoding orders severity: OKAY < EXOKAY < SLVERR < DECERR.
    function automatic resp_t merge_resp(resp_t a, resp_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic addr_t incr_next_addr(addr_t addr, logic [2:0] size);
        addr_t bytes;
        bytes = addr_t'(1) << size;
        return (addr + bytes) & ~(bytes - addr_t'(1));
    endfunction

    // len is the burst length captured at descriptor load, not the running count.
    function automatic addr_t wrap_next_addr(addr_t addr, logic [2:0] size, logic [7:0] len);
        addr_t bytes, wrap_len;
        bytes    = addr_t'(1) << size;
        wrap_len = (addr_t'(len) + addr_t'(1)) << size;
        return (addr & ~(wrap_len - addr_t'(1))) | ((addr + bytes) & (wrap_len - addr_t'(1)));
    endfunction
endpackage

// File: rtl/axi_llc_burst_addr_gen.sv
// rtl/axi_llc_burst_addr_gen.sv - per-beat AXI burst address and remaining-length tracker
module axi_llc_burst_addr_gen
    import axi_llc_burst_write_unit_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       next_i,
    input  addr_t      addr_i,
    input  logic [7:0] len_i,
    input  logic [2:0] size_i,
    input  burst_t     burst_i,
    output addr_t      addr_o,
    output logic       last_o
);
    addr_t      addr_q, addr_next;
    logic [7:0] len_q, len_init_q;
    logic [2:0] size_q;
    burst_t     burst_q;

    assign addr_o = addr_q;
    assign last_o = (len_q == 8'd0);

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            BURST_INCR: addr_next = incr_next_addr(addr_q, size_q);
            BURST_WRAP: addr_next = wrap_next_addr(addr_q, size_q, len_init_q);
            default:    addr_next = addr_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            len_q      <= '0;
            len_init_q <= '0;
            size_q     <= '0;
            burst_q    <= BURST_FIXED;
        end else if (load_i) begin
            addr_q     <= addr_i;
            len_q      <= len_i;
            len_init_q <= len_i;
            size_q     <= size_i;
            burst_q    <= burst_i;
        end else if (next_i) begin
            addr_q <= addr_next;
            len_q  <= len_q - 8'd1;
        end
    end
endmodule

// File: rtl/axi_llc_burst_write_unit_fifo.sv
// rtl/axi_llc_burst_write_unit_fifo.sv - non-fall-through stream FIFO for descriptors, W beats and B responses
module axi_llc_burst_write_unit_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic test_i,
    input  T     data_i,
    input  logic valid_i,
    output logic ready_o,
    output T     data_o,
    output logic valid_o,
    input  logic ready_i
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;

    T     mem [Depth];
    ptr_t rd_q, wr_q;
    cnt_t cnt_q;
    logic alive_q, push, pop, test_unused;

    assign test_unused = test_i;
    // ready stays low while in reset and for the first cycle after it
    assign ready_o = alive_q && (32'(cnt_q) != Depth);
    assign valid_o = (cnt_q != '0);
    assign data_o  = mem[rd_q];
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (push) wr_q <= (32'(wr_q) == Depth - 1) ? '0 : wr_q + ptr_t'(1);
            if (pop)  rd_q <= (32'(rd_q) == Depth - 1) ? '0 : rd_q + ptr_t'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + cnt_t'(1);
                2'b01:   cnt_q <= cnt_q - cnt_t'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/axi_llc_burst_write_unit.sv
// rtl/axi_llc_burst_write_unit.sv - LLC write unit: streams buffered W beats to the data ways per descriptor
module axi_llc_burst_write_unit
    import axi_llc_burst_write_unit_pkg::*;
#(
    parameter int unsigned WBufDepth     = WChanBufferDepth,
    parameter int unsigned DescFifoDepth = DefaultDescFifoDepth,
    parameter int unsigned BFifoDepth    = DefaultBFifoDepth,
    parameter bit          SkipEmptyStrb = 1'b1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     test_i,
    input  desc_t    desc_i,
    input  logic     desc_valid_i,
    output logic     desc_ready_o,
    input  w_chan_t  w_chan_slv_i,
    input  logic     w_chan_valid_i,
    output logic     w_chan_ready_o,
    output b_chan_t  b_chan_slv_o,
    output logic     b_chan_valid_o,
    input  logic     b_chan_ready_i,
    output way_inp_t way_inp_o,
    output logic     way_inp_valid_o,
    input  logic     way_inp_ready_i,
    output lock_t    w_unlock_o,
    output logic     w_unlock_req_o,
    input  logic     w_unlock_gnt_i,
    output logic     busy_o
);
    desc_t   desc_head;
    w_chan_t w_head;
    b_chan_t b_push_data;
    addr_t   cur_addr;
    logic    desc_head_valid, desc_pop, w_valid, w_pop, b_push, b_push_ready;
    logic    beat_last, skip, need_b, can_go, desc_done;

    logic                        active_q, x_last_q;
    logic [IdWidth-1:0]          id_q;
    resp_t                       resp_q, merged_q;
    logic [SetAssociativity-1:0] way_q;
    logic [IndexLength-1:0]      idx_q;

    axi_llc_burst_write_unit_fifo #(.Depth(DescFifoDepth), .T(desc_t)) u_desc_fifo (
        .clk_i, .rst_ni, .test_i,
        .data_i(desc_i), .valid_i(desc_valid_i), .ready_o(desc_ready_o),
        .data_o(desc_head), .valid_o(desc_head_valid), .ready_i(desc_pop)
    );

    axi_llc_burst_write_unit_fifo #(.Depth(WBufDepth), .T(w_chan_t)) u_w_fifo (
        .clk_i, .rst_ni, .test_i,
        .data_i(w_chan_slv_i), .valid_i(w_chan_valid_i), .ready_o(w_chan_ready_o),
        .data_o(w_head), .valid_o(w_valid), .ready_i(w_pop)
    );

    axi_llc_burst_write_unit_fifo #(.Depth(BFifoDepth), .T(b_chan_t)) u_b_fifo (
        .clk_i, .rst_ni, .test_i,
        .data_i(b_push_data), .valid_i(b_push), .ready_o(b_push_ready),
        .data_o(b_chan_slv_o), .valid_o(b_chan_valid_o), .ready_i(b_chan_ready_i)
    );

    axi_llc_burst_addr_gen u_addr_gen (
        .clk_i, .rst_ni,
        .load_i(desc_pop), .next_i(w_pop),
        .addr_i(desc_head.a_x_addr), .len_i(desc_head.a_x_len),
        .size_i(desc_head.a_x_size), .burst_i(desc_head.a_x_burst),
        .addr_o(cur_addr), .last_o(beat_last)
    );

    // Only the closing beat of an x_last descriptor needs B FIFO space.
    assign skip            = resp_q[1] || (SkipEmptyStrb && (w_head.strb == '0));
    assign need_b          = beat_last && x_last_q;
    assign can_go          = active_q && w_unlock_gnt_i && w_valid && (!need_b || b_push_ready);
    assign way_inp_valid_o = can_go && !skip;
    assign w_pop           = can_go && (skip || way_inp_ready_i);
    assign desc_done       = w_pop && beat_last;
    assign desc_pop        = desc_head_valid && (!active_q || desc_done);
    assign b_push          = desc_done && x_last_q;
    assign b_push_data     = '{id: id_q, resp: merge_resp(merged_q, resp_q)};
    assign busy_o          = active_q || desc_head_valid || b_chan_valid_o;

    always_comb begin
        way_inp_o            = '0;
        way_inp_o.cache_unit = WChanUnit;
        way_inp_o.we         = 1'b1;
        way_inp_o.way_ind    = way_q;
        way_inp_o.addr       = cur_addr;
        way_inp_o.line_addr  = cur_addr[LineOffset +: IndexLength];
        way_inp_o.blk_offset = cur_addr[ByteOffsetLength +: BlockOffsetLength];
        way_inp_o.data       = w_head.data;
        way_inp_o.strb       = w_head.strb;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q       <= 1'b0;
            x_last_q       <= 1'b0;
            id_q           <= '0;
            resp_q         <= RESP_OKAY;
            merged_q       <= RESP_OKAY;
            way_q          <= '0;
            idx_q          <= '0;
            w_unlock_req_o <= 1'b0;
            w_unlock_o     <= '0;
        end else begin
            w_unlock_req_o <= desc_done;
            if (desc_done) begin
                w_unlock_o <= '{index: idx_q, way_ind: way_q};
                merged_q   <= x_last_q ? RESP_OKAY : merge_resp(merged_q, resp_q);
            end
            if (desc_pop) begin
                active_q <= 1'b1;
                x_last_q <= desc_head.x_last;
                id_q     <= desc_head.a_x_id;
                resp_q   <= desc_head.x_resp;
                way_q    <= desc_head.way_ind;
                idx_q    <= desc_head.a_x_addr[LineOffset +: IndexLength];
            end else if (desc_done) begin
                active_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_llc_burst_write_unit.sv
// tb/tb_axi_llc_burst_write_unit.sv - directed bench for the LLC burst write unit
module tb_axi_llc_burst_write_unit;
    import axi_llc_burst_write_unit_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n, test, desc_valid, desc_ready, w_valid, w_ready;
    logic     b_valid, b_ready, way_valid, way_ready, unlock_req, gnt, busy;
    desc_t    desc;
    w_chan_t  w;
    b_chan_t  b;
    way_inp_t way;
    lock_t    unlock;
    int       cyc = 0;
    logic     throttle = 1'b0;
    int       total = 0;
    int       bad = 0;

    addr_t      way_addr[$];
    logic [2:0] way_blk[$], way_meta[$];
    logic [7:0] way_line[$];
    int         way_cyc[$], b_cyc[$], unlock_cyc[$];
    logic [3:0] b_id[$], unlock_way[$];
    resp_t      b_resp[$];
    logic [7:0] unlock_idx[$];

    axi_llc_burst_write_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .test_i(test),
        .desc_i(desc), .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
        .w_chan_slv_i(w), .w_chan_valid_i(w_valid), .w_chan_ready_o(w_ready),
        .b_chan_slv_o(b), .b_chan_valid_o(b_valid), .b_chan_ready_i(b_ready),
        .way_inp_o(way), .way_inp_valid_o(way_valid), .way_inp_ready_i(way_ready),
        .w_unlock_o(unlock), .w_unlock_req_o(unlock_req), .w_unlock_gnt_i(gnt),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign way_ready = !throttle || ((cyc % 3) != 0);

    always @(negedge clk) begin
        if (rst_n) begin
            if (way_valid && way_ready) begin
                way_addr.push_back(way.addr);
                way_blk.push_back(way.blk_offset);
                way_line.push_back(way.line_addr);
                way_meta.push_back({way.we, way.cache_unit});
                way_cyc.push_back(cyc);
            end
            if (b_valid && b_ready) begin
                b_id.push_back(b.id);
                b_resp.push_back(b.resp);
                b_cyc.push_back(cyc);
            end
            if (unlock_req) begin
                unlock_idx.push_back(unlock.index);
                unlock_way.push_back(unlock.way_ind);
                unlock_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        way_addr.delete(); way_blk.delete(); way_line.delete(); way_meta.delete(); way_cyc.delete();
        b_id.delete(); b_resp.delete(); b_cyc.delete();
        unlock_idx.delete(); unlock_way.delete(); unlock_cyc.delete();
    endtask

    function automatic desc_t mk_desc(input logic [3:0] id, input addr_t addr, input logic [7:0] len,
                                      input logic [2:0] size, input burst_t burst, input resp_t resp,
                                      input logic last);
        return '{a_x_id: id, a_x_addr: addr, a_x_len: len, a_x_size: size, a_x_burst: burst,
                 x_resp: resp, x_last: last, way_ind: 4'b0010};
    endfunction

    task automatic push_desc(input desc_t d);
        int n = 0;
        @(negedge clk);
        desc = d;
        desc_valid = 1'b1;
        while (!desc_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("desc_push_timeout", 1, 0);
        @(posedge clk); #1;
        desc_valid = 1'b0;
    endtask

    task automatic push_w(input logic [63:0] data, input logic [7:0] strb);
        int n = 0;
        @(negedge clk);
        w = '{data: data, strb: strb};
        w_valid = 1'b1;
        while (!w_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("w_push_timeout", 1, 0);
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    typedef struct packed {
        addr_t           addr;
        logic [2:0]      size;
        logic [7:0]      len;
        burst_t          burst;
        resp_t           resp;
        logic [3:0]      zero_beats;
        logic [2:0]      exp_ways;
        logic [3:0][31:0] exp_addr;
        resp_t           exp_b;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
        vecs[0] = '{addr: 32'h1000, size: 3'd3, len: 8'd3, burst: BURST_INCR, resp: RESP_OKAY, zero_beats: 4'b0000,
                    exp_ways: 3'd4, exp_addr: {32'h1018, 32'h1010, 32'h1008, 32'h1000}, exp_b: RESP_OKAY};
        vecs[1] = '{addr: 32'h1018, size: 3'd3, len: 8'd3, burst: BURST_WRAP, resp: RESP_OKAY, zero_beats: 4'b0000,
                    exp_ways: 3'd4, exp_addr: {32'h1010, 32'h1008, 32'h1000, 32'h1018}, exp_b: RESP_OKAY};
        vecs[2] = '{addr: 32'h2000, size: 3'd3, len: 8'd2, burst: BURST_INCR, resp: RESP_OKAY, zero_beats: 4'b0010,
                    exp_ways: 3'd2, exp_addr: {32'h0, 32'h0, 32'h2010, 32'h2000}, exp_b: RESP_OKAY};
        vecs[3] = '{addr: 32'h3004, size: 3'd2, len: 8'd1, burst: BURST_FIXED, resp: RESP_OKAY, zero_beats: 4'b0000,
                    exp_ways: 3'd2, exp_addr: {32'h0, 32'h0, 32'h3004, 32'h3004}, exp_b: RESP_OKAY};
        vecs[4] = '{addr: 32'h6000, size: 3'd3, len: 8'd1, burst: BURST_INCR, resp: RESP_DECERR, zero_beats: 4'b0000,
                    exp_ways: 3'd0, exp_addr: {32'h0, 32'h0, 32'h0, 32'h0}, exp_b: RESP_DECERR};
        vecs[5] = '{addr: 32'h1003, size: 3'd2, len: 8'd1, burst: BURST_INCR, resp: RESP_OKAY, zero_beats: 4'b0000,
                    exp_ways: 3'd2, exp_addr: {32'h0, 32'h0, 32'h1004, 32'h1003}, exp_b: RESP_OKAY};
        vecs[6] = '{addr: 32'h2004, size: 3'd2, len: 8'd1, burst: BURST_WRAP, resp: RESP_OKAY, zero_beats: 4'b0000,
                    exp_ways: 3'd2, exp_addr: {32'h0, 32'h0, 32'h2000, 32'h2004}, exp_b: RESP_OKAY};

        rst_n = 1'b0; test = 1'b0; desc = '0; desc_valid = 1'b0; w = '0; w_valid = 1'b0;
        b_ready = 1'b1; gnt = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_desc_ready", desc_ready, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_way_valid", way_valid, 0);
        check("rst_unlock_req", unlock_req, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            clear_logs();
            throttle = (i == 2 || i == 6);
            push_desc(mk_desc(4'(i + 1), vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].resp, 1'b1));
            for (int k = 0; k <= int'(vecs[i].len); k++)
                push_w(64'hA0 + 64'(k), vecs[i].zero_beats[k] ? 8'h00 : 8'hFF);
            wait_idle();
            check($sformatf("v%0d_way_count", i), way_addr.size(), vecs[i].exp_ways);
            for (int k = 0; k < int'(vecs[i].exp_ways) && k < way_addr.size(); k++) begin
                addr_t e;
                e = vecs[i].exp_addr[k];
                check($sformatf("v%0d_addr%0d", i, k), way_addr[k], e);
                check($sformatf("v%0d_blk%0d", i, k), way_blk[k], e[5:3]);
                check($sformatf("v%0d_line%0d", i, k), way_line[k], e[13:6]);
                check($sformatf("v%0d_meta%0d", i, k), way_meta[k], 3'b110);
            end
            check($sformatf("v%0d_b_count", i), b_resp.size(), 1);
            if (b_resp.size() > 0) begin
                check($sformatf("v%0d_b_resp", i), b_resp[0], vecs[i].exp_b);
                check($sformatf("v%0d_b_id", i), b_id[0], i + 1);
            end
            check($sformatf("v%0d_unlock_count", i), unlock_idx.size(), 1);
            if (unlock_idx.size() > 0) begin
                check($sformatf("v%0d_unlock_idx", i), unlock_idx[0], vecs[i].addr[13:6]);
                check($sformatf("v%0d_unlock_way", i), unlock_way[0], 4'b0010);
            end
            if (i == 0 && b_cyc.size() > 0 && way_cyc.size() == 4)
                check("v0_b_latency", b_cyc[0] - way_cyc[3], 1);
        end
        throttle = 1'b0;

        // split burst: OKAY part then SLVERR part, one merged B
        clear_logs();
        gnt = 1'b0;
        push_desc(mk_desc(4'd5, 32'h4000, 8'd1, 3'd3, BURST_INCR, RESP_OKAY, 1'b0));
        push_desc(mk_desc(4'd5, 32'h4010, 8'd1, 3'd3, BURST_INCR, RESP_SLVERR, 1'b1));
        for (int k = 0; k < 4; k++) push_w(64'hB0 + 64'(k), 8'hFF);
        @(negedge clk);
        gnt = 1'b1;
        wait_idle();
        check("split_way_count", way_addr.size(), 2);
        if (way_addr.size() == 2) begin
            check("split_addr0", way_addr[0], 32'h4000);
            check("split_addr1", way_addr[1], 32'h4008);
        end
        check("split_unlock_count", unlock_cyc.size(), 2);
        if (unlock_cyc.size() == 2) check("split_no_bubble", unlock_cyc[1] - unlock_cyc[0], 2);
        check("split_b_count", b_resp.size(), 1);
        if (b_resp.size() == 1) begin
            check("split_b_resp", b_resp[0], RESP_SLVERR);
            check("split_b_id", b_id[0], 5);
        end

        // B FIFO full stalls only the closing beat
        clear_logs();
        b_ready = 1'b0;
        for (int k = 1; k <= 3; k++) push_desc(mk_desc(4'(k), 32'h7000 + 32'(k * 64), 8'd0, 3'd3, BURST_INCR, RESP_OKAY, 1'b1));
        for (int k = 0; k < 3; k++) push_w(64'hC0 + 64'(k), 8'hFF);
        repeat (10) @(negedge clk);
        check("bstall_way_count", way_addr.size(), 2);
        check("bstall_way_valid", way_valid, 0);
        check("bstall_b_valid", b_valid, 1);
        check("bstall_busy", busy, 1);
        check("bstall_unlock_count", unlock_cyc.size(), 2);
        b_ready = 1'b1;
        wait_idle();
        check("bstall_way_count_after", way_addr.size(), 3);
        check("bstall_b_count", b_id.size(), 3);
        for (int k = 0; k < 3 && k < b_id.size(); k++) check($sformatf("bstall_b_order%0d", k), b_id[k], k + 1);

        // grant low freezes progress; reset mid-burst drops everything
        clear_logs();
        push_desc(mk_desc(4'd7, 32'h5000, 8'd3, 3'd3, BURST_INCR, RESP_OKAY, 1'b1));
        push_w(64'hD0, 8'hFF);
        push_w(64'hD1, 8'hFF);
        repeat (4) @(negedge clk);
        check("gnt_way_count_before", way_addr.size(), 2);
        gnt = 1'b0;
        push_w(64'hD2, 8'hFF);
        push_w(64'hD3, 8'hFF);
        repeat (10) @(negedge clk);
        check("gnt_low_way_count", way_addr.size(), 2);
        check("gnt_low_way_valid", way_valid, 0);
        check("gnt_low_unlock_count", unlock_cyc.size(), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_way_valid", way_valid, 0);
        check("midrst_b_valid", b_valid, 0);
        check("midrst_unlock_req", unlock_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_desc_ready", desc_ready, 0);
        check("midrst_w_ready", w_ready, 0);
        check("midrst_unlock", unlock, 0);
        rst_n = 1'b1;
        gnt = 1'b1;
        repeat (10) @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_b_count", b_id.size(), 0);
        check("postrst_way_count", way_addr.size(), 2);
        check("postrst_unlock_count", unlock_cyc.size(), 0);
        check("postrst_desc_ready", desc_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_llc_burst_write_unit.md
Name: axi_llc_burst_write_unit

Overview:
- Next-generation LLC write unit. Sits between the hit/miss pipeline and the data ways.
- Consumes write descriptors from a queue and streams buffered W beats to the data ways.
- Merges responses across split descriptors, skips zero-strobe beats, and issues B responses through a parametrised FIFO.
- Each finished descriptor unlocks its line via the lock interface.

Parameters:
- Cfg, '{default:'0}, static LLC configuration (index, block-offset and byte-offset lengths).
- AxiCfg, '{default:'0}, static LLC AXI configuration (AddrWidthFull).
- WBufDepth, axi_llc_pkg::WChanBufferDepth, W beat buffer depth, >=1.
- DescFifoDepth, 2, descriptor queue depth, >=1.
- BFifoDepth, 2, B response FIFO depth, >=1.
- SkipEmptyStrb, 1'b1, consume strb=='0 beats without a data-way request.
- desc_t, way_inp_t, lock_t, w_chan_t, b_chan_t: logic, payload types.

Ports:
- clk_i  in  1  clock, positive edge.
- rst_ni  in  1  asynchronous reset, active low.
- test_i  in  1  testmode for FIFOs.
- desc_i  in  desc_t  write descriptor.
- desc_valid_i / desc_ready_o  in/out  1  descriptor handshake.
- w_chan_slv_i  in  w_chan_t  AXI W beat.
- w_chan_valid_i / w_chan_ready_o  in/out  1  W handshake.
- b_chan_slv_o  out  b_chan_t  AXI B response.
- b_chan_valid_o / b_chan_ready_i  out/in  1  B handshake.
- way_inp_o  out  way_inp_t  data-way write request (cache_unit=WChanUnit, we=1).
- way_inp_valid_o / way_inp_ready_i  out/in  1  data-way handshake.
- w_unlock_o  out  lock_t  index and way_ind of the line being unlocked.
- w_unlock_req_o  out  1  unlock request.
- w_unlock_gnt_i  in  1  unlock may be granted; the unit acts only while high.
- busy_o  out  1  descriptor active, descriptor queue non-empty, or B FIFO non-empty.

Behaviour:
- Reset values: all valids, readys and req outputs 0; busy_o=0; descriptor register, merged resp and FIFOs cleared. Reset mid-burst drops all state; no B is issued and no unlock is requested.
- Descriptor queue is a stream_fifo, non-fall-through. desc_ready_o = !full.
- Active-descriptor register loads from the queue head when idle, or in the same cycle as the last beat of the current descriptor. Back-to-back descriptors run with zero bubble.
- W beats pass through a WBufDepth stream_fifo, non-fall-through.
- Beat processing requires an active descriptor and w_unlock_gnt_i=1.
- Normal case:
  - way_inp_valid_o = w_valid.
  - W pop on way_inp_ready_i.
  - blk_offset = addr[ByteOffsetLength +: BlockOffsetLength].
  - line_addr = addr[LineOffset +: IndexLength].
- Error case: x_resp is SLVERR or DECERR -> pop beats with no way request.
- SkipEmptyStrb=1 and strb=='0 -> pop beat with no way request. Address and length still advance.
- Address update per beat, where bytes = 1<<size:
  - INCR: aligned_addr(addr+bytes, size).
  - FIXED: unchanged.
  - WRAP: true AXI wrap. wrap_len = (len_at_load+1)*bytes, latched at load. New addr = (addr & ~(wrap_len-1)) | ((addr+bytes) & (wrap_len-1)). Arithmetic is in AddrWidthFull bits.
- Last beat (len==0) of a descriptor:
  - Pulse w_unlock_req_o for one cycle.
  - merged_resp_d = max(merged_resp_q, x_resp), numeric AXI encoding.
  - If x_last: push B {id=a_x_id, resp=merged} and clear merged_resp to OKAY.
- B FIFO full: only the final beat of an x_last descriptor stalls. Earlier beats proceed.
- B latency: b_chan_valid_o rises one cycle after the final W pop, at the earliest.
- A descriptor arriving while the queue is full waits with no loss. W beats may arrive before their descriptor and are buffered up to WBufDepth.

Decomposition:
- Extend axi_llc_pkg with:
  - DescFifoDepth/BFifoDepth defaults.
  - function merge_resp(resp_t a, resp_t b).
  - function wrap_next_addr(addr, size, len).
- Sub-module axi_llc_burst_addr_gen: latches addr/len/burst/size on load and emits next addr, len==0 and wrap mask. This isolates the burst arithmetic for a unit test.
- FIFOs reuse the common_cells stream_fifo.

Test Plan:
- INCR, addr 0x1000, size 3, len 3, x_last=1, one way: 4 way writes with blk_offset 0,1,2,3; one unlock pulse; B OKAY one cycle after the 4th pop.
- WRAP, addr 0x1018, size 3, len 3: write addresses 0x1018, 0x1000, 0x1008, 0x1010; unlock on the 4th beat.
- Split burst of 2 descriptors (x_last=0 OKAY, then x_last=1 with x_resp SLVERR), 2 beats each: 2 way writes then 2 silently consumed beats; 2 unlock pulses; exactly one B with resp SLVERR; no bubble between descriptors.
- Beat with strb=0 among 3 INCR beats, SkipEmptyStrb=1: only 2 way requests; address still advances across the skipped beat.
- b_chan_ready_i=0 with BFifoDepth=2 and 3 single-beat x_last descriptors: 2 B responses queued; 3rd final beat stalls (w_chan not popped); releasing ready drains all B in order.
- Deassert w_unlock_gnt_i mid-burst, then assert rst_ni=0 mid-burst: no progress while gnt is low; after reset all outputs 0, busy_o=0, no spurious B.
